// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC mode encodings
// and instruction-format constants.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pc_sel_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned JUMP_IDX_W  = 26;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: push/pop/replace with a saturating count,
// sticky overflow when the oldest entry is overwritten, and an underflow pulse.
module ras_stack #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] top,
  output logic              valid,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_W-1:0] entries [DEPTH];
  logic [PW-1:0]     top_ptr;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // top_ptr addresses the newest entry; when full, the slot after it is the
  // oldest, so a push naturally overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      top_ptr   <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (push && (!pop || empty)) begin
        entries[top_ptr + PW'(1)] <= wdata;
        top_ptr                   <= top_ptr + PW'(1);
        if (full) begin
          overflow <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
      end else if (push && pop) begin
        entries[top_ptr] <= wdata;
      end else if (pop) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          top_ptr <= top_ptr - PW'(1);
          count   <= count - CW'(1);
        end
      end
    end
  end

  assign top   = empty ? '0 : entries[top_ptr];
  assign valid = !empty;

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with four next-PC modes, stall support and an
// advisory return-address stack fed with the link address.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  stall,
  input  logic [1:0]            pc_sel,
  input  logic                  branch_taken,
  input  logic [ADDR_W-1:0]     imm_ext,
  input  logic [JUMP_IDX_W-1:0] jump_target,
  input  logic [ADDR_W-1:0]     reg_target,
  input  logic                  link,
  input  logic                  ret,
  output logic [ADDR_W-1:0]     pc,
  output logic [ADDR_W-1:0]     pc_plus4,
  output logic [ADDR_W-1:0]     ras_top,
  output logic                  ras_valid,
  output logic                  ras_overflow,
  output logic                  misaligned,
  output logic                  ras_underflow
);

  localparam int unsigned REGION_LO = JUMP_IDX_W + 2;

  pc_sel_e           mode;
  logic [ADDR_W-1:0] next_pc;

  assign mode     = pc_sel_e'(pc_sel);
  assign pc_plus4 = pc + ADDR_W'(INSTR_BYTES);

  always_comb begin
    next_pc = pc_plus4;
    case (mode)
      PC_SEQ:  next_pc = pc_plus4;
      PC_BR:   next_pc = branch_taken ? (pc_plus4 + (imm_ext << 2)) : pc_plus4;
      PC_J:    next_pc = {pc_plus4[ADDR_W-1:REGION_LO], jump_target, 2'b00};
      PC_JR:   next_pc = {reg_target[ADDR_W-1:2], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc         <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      misaligned <= !stall && (mode == PC_JR) && (reg_target[1:0] != 2'b00);
      if (!stall) begin
        pc <= next_pc;
      end
    end
  end

  ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (Reset),
    .push      (link && !stall),
    .pop       (ret && !stall),
    .wdata     (pc_plus4),
    .top       (ras_top),
    .valid     (ras_valid),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic against a queue-based reference model of the PC and return stack.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        Reset, stall, branch_taken, link, ret;
  logic [1:0]  pc_sel;
  logic [31:0] imm_ext, reg_target;
  logic [25:0] jump_target;
  logic [31:0] pc, pc_plus4, ras_top;
  logic        ras_valid, ras_overflow, misaligned, ras_underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_mis, m_unf;

  pc_sequencer #(
    .ADDR_W    (32),
    .RESET_PC  (32'h0),
    .RAS_DEPTH (4)
  ) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .stall         (stall),
    .pc_sel        (pc_sel),
    .branch_taken  (branch_taken),
    .imm_ext       (imm_ext),
    .jump_target   (jump_target),
    .reg_target    (reg_target),
    .link          (link),
    .ret           (ret),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ras_top       (ras_top),
    .ras_valid     (ras_valid),
    .ras_overflow  (ras_overflow),
    .misaligned    (misaligned),
    .ras_underflow (ras_underflow)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] exp_top();
    if (m_ras.size() == 0) return 32'h0;
    return m_ras[m_ras.size()-1];
  endfunction

  // Advance the model by one clock using the currently driven inputs, then
  // let the DUT take the same edge and settle.
  task automatic tick();
    logic [31:0] p4, npc;
    if (Reset) begin
      m_pc = 32'h0; m_ras.delete(); m_ovf = 0; m_mis = 0; m_unf = 0;
    end else if (stall) begin
      m_mis = 0; m_unf = 0;
    end else begin
      p4 = m_pc + 32'd4;
      case (pc_sel)
        2'd0: npc = p4;
        2'd1: npc = branch_taken ? p4 + imm_ext * 32'd4 : p4;
        2'd2: npc = (p4 & 32'hF000_0000) | ({6'b0, jump_target} * 32'd4);
        default: npc = reg_target & ~32'd3;
      endcase
      m_mis = (pc_sel == 2'd3) && (reg_target % 4 != 0);
      m_unf = 0;
      if (link && ret) begin
        if (m_ras.size() == 0) m_ras.push_back(p4);
        else m_ras[m_ras.size()-1] = p4;
      end else if (link) begin
        if (m_ras.size() == 4) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
        m_ras.push_back(p4);
      end else if (ret) begin
        if (m_ras.size() == 0) m_unf = 1;
        else void'(m_ras.pop_back());
      end
      m_pc = npc;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic st, input logic [1:0] sel, input logic bt,
                       input logic [31:0] imm, input logic [25:0] jt,
                       input logic [31:0] rt, input logic lk, input logic rr);
    Reset = 0; stall = st; pc_sel = sel; branch_taken = bt; imm_ext = imm;
    jump_target = jt; reg_target = rt; link = lk; ret = rr;
    tick();
  endtask

  task automatic goto_pc(input logic [31:0] a);
    drive(0, 2'd3, 0, 32'h0, 26'h0, a, 0, 0);
  endtask

  task automatic do_reset();
    Reset = 1; stall = 1; link = 1; ret = 0; pc_sel = 2'd2;
    tick();
    Reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 2'd0, 0, 0, 0, 0, 1, 0);
    drive(0, 2'd0, 0, 0, 0, 0, 1, 0);
    // Reset asserted while stalled and pushing must still win.
    do_reset();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (ras_valid !== 1'b0 || ras_top !== 32'h0) begin errors++; $display("FAIL reset_ras valid=%b top=%h exp 0/0", ras_valid, ras_top); end
    checks++; if ({ras_overflow, misaligned, ras_underflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {ras_overflow, misaligned, ras_underflow}); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 2'd0, 0, 0, 0, 0, 0, 0);
      checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc step=%0d got=%h exp=%h", i, pc, 32'(4 * i)); end
    end
    checks++; if (pc_plus4 !== 32'd16) begin errors++; $display("FAIL seq_pc_plus4 got=%h exp=%h", pc_plus4, 32'd16); end
  endtask

  task automatic test_branch();
    goto_pc(32'h100);
    drive(0, 2'd1, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    checks++; if (pc !== 32'hFC) begin errors++; $display("FAIL branch_taken got=%h exp=%h", pc, 32'hFC); end
    goto_pc(32'h100);
    drive(0, 2'd1, 0, 32'hFFFF_FFFE, 0, 0, 0, 0);
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL branch_not_taken got=%h exp=%h", pc, 32'h104); end
    goto_pc(32'hFFFF_FFFC);
    drive(0, 2'd0, 0, 0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap got=%h exp=%h", pc, 32'h0); end
  endtask

  task automatic test_jump();
    goto_pc(32'h1000_0008);
    drive(0, 2'd2, 0, 0, 26'h40, 0, 0, 0);
    checks++; if (pc !== 32'h1000_0100) begin errors++; $display("FAIL jump_j got=%h exp=%h", pc, 32'h1000_0100); end
    drive(0, 2'd3, 0, 0, 0, 32'h2003, 0, 0);
    checks++; if (pc !== 32'h2000 || misaligned !== 1'b1) begin errors++; $display("FAIL jump_jr pc=%h mis=%b exp=%h/1", pc, misaligned, 32'h2000); end
    drive(0, 2'd0, 0, 0, 0, 0, 0, 0);
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL misaligned_pulse got=%b exp=0", misaligned); end
  endtask

  task automatic test_stall();
    logic [31:0] p, t;
    logic        v;
    p = pc; t = ras_top; v = ras_valid;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'd2, 0, 0, 26'h123, 0, 1, 0);
      checks++; if (pc !== p || ras_top !== t || ras_valid !== v) begin errors++; $display("FAIL stall_hold pc=%h top=%h exp=%h/%h", pc, ras_top, p, t); end
    end
    drive(0, 2'd2, 0, 0, 26'h123, 0, 1, 0);
    checks++; if (pc !== (((p + 32'd4) & 32'hF000_0000) | 32'h48C)) begin errors++; $display("FAIL stall_release_pc got=%h exp=%h", pc, ((p + 32'd4) & 32'hF000_0000) | 32'h48C); end
    checks++; if (ras_top !== p + 32'd4 || ras_valid !== 1'b1) begin errors++; $display("FAIL stall_release_push top=%h exp=%h", ras_top, p + 32'd4); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_pop [3];
    exp_pop[0] = 32'h44; exp_pop[1] = 32'h34; exp_pop[2] = 32'h24;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      goto_pc(32'(16 * i));
      drive(0, 2'd0, 0, 0, 0, 0, 1, 0);
    end
    checks++; if (ras_top !== 32'h54 || ras_overflow !== 1'b1) begin errors++; $display("FAIL ras_overflow top=%h ovf=%b exp=54/1", ras_top, ras_overflow); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'd0, 0, 0, 0, 0, 0, 1);
      checks++; if (ras_top !== exp_pop[i]) begin errors++; $display("FAIL ras_pop idx=%0d got=%h exp=%h", i, ras_top, exp_pop[i]); end
    end
    drive(0, 2'd0, 0, 0, 0, 0, 0, 1);
    checks++; if (ras_valid !== 1'b0 || ras_top !== 32'h0) begin errors++; $display("FAIL ras_empty valid=%b top=%h exp 0/0", ras_valid, ras_top); end
    drive(0, 2'd0, 0, 0, 0, 0, 0, 1);
    checks++; if (ras_underflow !== 1'b1 || ras_valid !== 1'b0) begin errors++; $display("FAIL ras_underflow unf=%b valid=%b exp 1/0", ras_underflow, ras_valid); end
    drive(0, 2'd0, 0, 0, 0, 0, 0, 0);
    checks++; if (ras_underflow !== 1'b0 || ras_overflow !== 1'b1) begin errors++; $display("FAIL flag_after unf=%b ovf=%b exp 0/1", ras_underflow, ras_overflow); end
  endtask

  task automatic test_link_ret();
    do_reset();
    goto_pc(32'h10); drive(0, 2'd0, 0, 0, 0, 0, 1, 0);
    goto_pc(32'h20); drive(0, 2'd0, 0, 0, 0, 0, 1, 0);
    goto_pc(32'h80);
    drive(0, 2'd0, 0, 0, 0, 0, 1, 1);
    checks++; if (ras_top !== 32'h84 || ras_valid !== 1'b1) begin errors++; $display("FAIL link_ret_replace top=%h exp=%h", ras_top, 32'h84); end
    drive(0, 2'd0, 0, 0, 0, 0, 0, 1);
    checks++; if (ras_top !== 32'h14) begin errors++; $display("FAIL link_ret_count top=%h exp=%h", ras_top, 32'h14); end
    drive(0, 2'd0, 0, 0, 0, 0, 0, 1);
    goto_pc(32'h80);
    drive(0, 2'd0, 0, 0, 0, 0, 1, 1);
    checks++; if (ras_top !== 32'h84 || ras_valid !== 1'b1 || ras_underflow !== 1'b0) begin errors++; $display("FAIL link_ret_empty top=%h unf=%b exp=84/0", ras_top, ras_underflow); end
    drive(0, 2'd0, 0, 0, 0, 0, 0, 1);
    checks++; if (ras_valid !== 1'b0 || ras_underflow !== 1'b0) begin errors++; $display("FAIL link_ret_single valid=%b unf=%b exp 0/0", ras_valid, ras_underflow); end
  endtask

  task automatic test_random();
    logic [31:0] imm;
    for (int n = 0; n < 600; n++) begin
      imm = ($urandom_range(0, 1) == 0) ? 32'($signed(8'($urandom))) : 32'($urandom);
      Reset = ($urandom_range(0, 79) == 0);
      stall = ($urandom_range(0, 3) == 0);
      pc_sel = 2'($urandom);
      branch_taken = 1'($urandom);
      imm_ext = imm;
      jump_target = 26'($urandom);
      reg_target = 32'($urandom);
      link = ($urandom_range(0, 2) == 0);
      ret = ($urandom_range(0, 2) == 0);
      tick();
      checks++; if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rand_pc n=%0d pc=%h p4=%h exp=%h", n, pc, pc_plus4, m_pc); end
      checks++; if (ras_top !== exp_top() || ras_valid !== (m_ras.size() != 0)) begin errors++; $display("FAIL rand_ras n=%0d top=%h valid=%b exp=%h/%b", n, ras_top, ras_valid, exp_top(), m_ras.size() != 0); end
      checks++; if ({ras_overflow, misaligned, ras_underflow} !== {m_ovf, m_mis, m_unf}) begin errors++; $display("FAIL rand_flags n=%0d got=%b exp=%b", n, {ras_overflow, misaligned, ras_underflow}, {m_ovf, m_mis, m_unf}); end
    end
  endtask

  initial begin
    Reset = 1; stall = 1; pc_sel = 2'd0; branch_taken = 0; imm_ext = '0;
    jump_target = '0; reg_target = '0; link = 0; ret = 0;
    m_pc = '0; m_ovf = 0; m_mis = 0; m_unf = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_ras_overflow();
    test_link_ret();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
